// File: rtl/perceptron_trainer_if.sv
// rtl/perceptron_trainer_if.sv - sample/result/readback bundle for perceptron_trainer (PERCEPTRON_WT_LOAD_EN adds weight load)
interface perceptron_trainer_if #(
  parameter int N_IN     = 8,
  parameter int WEIGHT_W = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [N_IN-1:0]            in_bits;
  logic                       exp_res;
  logic                       train_en;
  logic                       result;
  logic                       result_valid;
  logic                       err;
  logic                       epoch_done;
  logic                       converged;
  logic [2:0]                 wt_sel;
  logic signed [WEIGHT_W-1:0] wt_out;
  logic signed [WEIGHT_W-1:0] thresh_out;
`ifdef PERCEPTRON_WT_LOAD_EN
  logic                       wt_load;
  logic [WEIGHT_W-1:0]        wt_load_data;

  modport master (
    output in_valid, in_bits, exp_res, train_en, wt_sel, wt_load, wt_load_data,
    input  in_ready, result, result_valid, err, epoch_done, converged, wt_out, thresh_out
  );
  modport slave (
    input  in_valid, in_bits, exp_res, train_en, wt_sel, wt_load, wt_load_data,
    output in_ready, result, result_valid, err, epoch_done, converged, wt_out, thresh_out
  );
`else
  modport master (
    output in_valid, in_bits, exp_res, train_en, wt_sel,
    input  in_ready, result, result_valid, err, epoch_done, converged, wt_out, thresh_out
  );
  modport slave (
    input  in_valid, in_bits, exp_res, train_en, wt_sel,
    output in_ready, result, result_valid, err, epoch_done, converged, wt_out, thresh_out
  );
`endif
endinterface

// File: rtl/perceptron_trainer.sv
// rtl/perceptron_trainer.sv - serial-accumulate step perceptron with learning-rule update
// Optional PERCEPTRON_WT_LOAD_EN: direct weight load while idle.
module perceptron_trainer #(
  parameter int N_IN        = 8,
  parameter int WEIGHT_W    = 8,
  parameter int LR          = 1,
  parameter int EPOCH_LEN   = 4,
  parameter int INIT_THRESH = 8
) (
  input logic                 clk,
  input logic                 reset,
  perceptron_trainer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, UPDATE} state_t;

  localparam int ACC_W = WEIGHT_W + 3;
  localparam int SUM_W = WEIGHT_W + 2;
  localparam int IDX_W = $clog2(N_IN);
  localparam int CNT_W = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
  localparam logic signed [SUM_W-1:0]    W_MAX    = SUM_W'((1 << (WEIGHT_W-1)) - 1);
  localparam logic signed [SUM_W-1:0]    W_MIN    = SUM_W'(-(1 << (WEIGHT_W-1)));
  localparam logic signed [SUM_W-1:0]    LR_S     = SUM_W'(LR);
  localparam logic signed [WEIGHT_W-1:0] TH_INIT  = WEIGHT_W'(INIT_THRESH);
  localparam logic [CNT_W-1:0]           CNT_LAST = CNT_W'(EPOCH_LEN - 1);
  localparam logic [IDX_W-1:0]           IDX_LAST = IDX_W'(N_IN - 1);

  state_t                     state, state_n;
  logic signed [WEIGHT_W-1:0] weight [N_IN];
  logic signed [WEIGHT_W-1:0] thresh;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    w_x, th_x;
  logic [IDX_W-1:0]           idx;
  logic [N_IN-1:0]            bits_q;
  logic                       exp_q, train_q;
  logic                       result_q, err_q, valid_q, epoch_q, conv_q;
  logic [CNT_W-1:0]           sample_cnt;
  logic                       epoch_err;
  logic                       load_now, in_ready_c, ge;

  // Widened add/subtract of LR, clamped to the signed weight range.
  function automatic logic signed [WEIGHT_W-1:0] sat_step(input logic signed [WEIGHT_W-1:0] v,
                                                          input logic up);
    logic signed [SUM_W-1:0]    s;
    logic signed [WEIGHT_W-1:0] r;
    s = $signed({{2{v[WEIGHT_W-1]}}, v});
    s = up ? s + LR_S : s - LR_S;
    if (s > W_MAX)      r = W_MAX[WEIGHT_W-1:0];
    else if (s < W_MIN) r = W_MIN[WEIGHT_W-1:0];
    else                r = s[WEIGHT_W-1:0];
    return r;
  endfunction

`ifdef PERCEPTRON_WT_LOAD_EN
  assign load_now = (state == IDLE) && bus.wt_load;
`else
  assign load_now = 1'b0;
`endif

  assign w_x  = $signed({{3{weight[idx][WEIGHT_W-1]}}, weight[idx]});
  assign th_x = $signed({{3{thresh[WEIGHT_W-1]}}, thresh});
  assign ge   = (acc >= th_x);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    in_ready_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = !load_now;
        if (bus.in_valid && !load_now) state_n = ACCUM;
      end
      ACCUM:   if (idx == IDX_LAST) state_n = DECIDE;
      DECIDE:  state_n = UPDATE;
      UPDATE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < N_IN; i++) weight[i] <= '0;
      thresh     <= TH_INIT;
      acc        <= '0;
      idx        <= '0;
      bits_q     <= '0;
      exp_q      <= 1'b0;
      train_q    <= 1'b0;
      result_q   <= 1'b0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      epoch_q    <= 1'b0;
      conv_q     <= 1'b0;
      sample_cnt <= '0;
      epoch_err  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      epoch_q <= 1'b0;
      case (state)
        IDLE: begin
`ifdef PERCEPTRON_WT_LOAD_EN
          if (load_now) weight[bus.wt_sel] <= bus.wt_load_data;
`endif
          if (bus.in_valid && in_ready_c) begin
            bits_q  <= bus.in_bits;
            exp_q   <= bus.exp_res;
            train_q <= bus.train_en;
            acc     <= '0;
            idx     <= '0;
          end
        end
        ACCUM: begin
          if (bits_q[idx]) acc <= acc + w_x;
          idx <= idx + 1'b1;
        end
        DECIDE: begin
          result_q <= ge;
          err_q    <= ge ^ exp_q;
        end
        UPDATE: begin
          valid_q <= 1'b1;
          // A miss with exp=1 means the neuron fired low: push weights up, threshold down.
          if (train_q && err_q) begin
            for (int i = 0; i < N_IN; i++)
              if (bits_q[i]) weight[i] <= sat_step(weight[i], exp_q);
            thresh <= sat_step(thresh, !exp_q);
          end
          if (sample_cnt == CNT_LAST) begin
            epoch_q    <= 1'b1;
            conv_q     <= !(epoch_err || err_q);
            sample_cnt <= '0;
            epoch_err  <= 1'b0;
          end else begin
            sample_cnt <= sample_cnt + 1'b1;
            epoch_err  <= epoch_err || err_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.result       = result_q;
  assign bus.err          = err_q;
  assign bus.result_valid = valid_q;
  assign bus.epoch_done   = epoch_q;
  assign bus.converged    = conv_q;
  assign bus.wt_out       = weight[bus.wt_sel];
  assign bus.thresh_out   = thresh;
endmodule

// File: tb/tb_perceptron_trainer.sv
// tb/tb_perceptron_trainer.sv - directed bench for perceptron_trainer (default and 4-bit saturation builds)
module tb_perceptron_trainer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  perceptron_trainer_if #(.N_IN(8), .WEIGHT_W(8)) bus ();
  perceptron_trainer_if #(.N_IN(8), .WEIGHT_W(4)) sbus ();

  perceptron_trainer u_dut (.clk(clk), .reset(reset), .bus(bus));
  perceptron_trainer #(.WEIGHT_W(4), .LR(6), .INIT_THRESH(7)) u_sat (.clk(clk), .reset(reset), .bus(sbus));

  int total = 0;
  int bad   = 0;

  logic [7:0] sat_bits [9] = '{8'h00, 8'h00, 8'h02, 8'h03, 8'h02, 8'h03, 8'h02, 8'h00, 8'h02};
  logic       sat_exp  [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic       sat_res  [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  int         sat_th   [9] = '{1, -5, 1, -5, 1, -5, 1, -5, -8};

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid  = 1'b0;
    sbus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic e, input logic t,
                      output logic r, output logic er, output logic ed, output logic cv);
    int k;
    bus.in_bits = b; bus.exp_res = e; bus.train_en = t; bus.in_valid = 1'b1;
    #1 chk("in_ready_idle", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.train_en = ~t;
    k = 0;
    while (!bus.result_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, 10);
    r = bus.result; er = bus.err; ed = bus.epoch_done; cv = bus.converged;
  endtask

  task automatic send_sat(input logic [7:0] b, input logic e, output logic r, output logic er);
    int k;
    sbus.in_bits = b; sbus.exp_res = e; sbus.train_en = 1'b1; sbus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sbus.in_valid = 1'b0;
    k = 0;
    while (!sbus.result_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("sat_latency", k, 10);
    r = sbus.result; er = sbus.err;
  endtask

  initial begin
    logic r, er, ed, cv;
    int acc_n, rv_n, low_n;
    bus.in_bits = '0; bus.exp_res = 1'b0; bus.train_en = 1'b0; bus.in_valid = 1'b0; bus.wt_sel = '0;
    sbus.in_bits = '0; sbus.exp_res = 1'b0; sbus.train_en = 1'b0; sbus.in_valid = 1'b0; sbus.wt_sel = '0;
`ifdef PERCEPTRON_WT_LOAD_EN
    bus.wt_load = 1'b0; bus.wt_load_data = '0;
    sbus.wt_load = 1'b0; sbus.wt_load_data = '0;
`endif

    // Reset state
    do_reset;
    #1;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_result", bus.result, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_epoch_done", bus.epoch_done, 0);
    chk("rst_converged", bus.converged, 0);
    chk("rst_thresh", bus.thresh_out, 8);
    for (int i = 0; i < 8; i++) begin
      bus.wt_sel = 3'(i);
      #1 chk($sformatf("rst_w%0d", i), bus.wt_out, 0);
    end
    @(negedge clk);

    // Eight training samples of 0xFF with target 1: only the first misses
    for (int s = 0; s < 8; s++) begin
      send(8'hFF, 1'b1, 1'b1, r, er, ed, cv);
      chk($sformatf("s%0d_result", s + 1), r, (s == 0) ? 0 : 1);
      chk($sformatf("s%0d_err", s + 1), er, (s == 0) ? 1 : 0);
      chk($sformatf("s%0d_epoch_done", s + 1), ed, (s == 3 || s == 7) ? 1 : 0);
      chk($sformatf("s%0d_converged", s + 1), cv, (s == 7) ? 1 : 0);
      if (s == 0) begin
        chk("s1_thresh", bus.thresh_out, 7);
        for (int i = 0; i < 8; i++) begin
          bus.wt_sel = 3'(i);
          #1 chk($sformatf("s1_w%0d", i), bus.wt_out, 1);
        end
        @(negedge clk);
      end
    end

    // Inference-only miss: no update, error still counted in the epoch
    send(8'hFF, 1'b0, 1'b0, r, er, ed, cv);
    chk("inf_result", r, 1);
    chk("inf_err", er, 1);
    chk("inf_thresh", bus.thresh_out, 7);
    bus.wt_sel = 3'd5;
    #1 chk("inf_w5", bus.wt_out, 1);
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      send(8'hFF, 1'b1, 1'b1, r, er, ed, cv);
      chk($sformatf("e3_s%0d_err", s), er, 0);
      chk($sformatf("e3_s%0d_epoch_done", s), ed, (s == 2) ? 1 : 0);
      chk($sformatf("e3_s%0d_converged", s), cv, (s == 2) ? 0 : 1);
    end

    // in_valid held high: one accept per 11 cycles
    do_reset;
    bus.in_bits = 8'h00; bus.exp_res = 1'b0; bus.train_en = 1'b0; bus.in_valid = 1'b1;
    acc_n = 0; rv_n = 0; low_n = 0;
    for (int i = 0; i < 34; i++) begin
      if (i == 33) bus.in_valid = 1'b0;
      if (bus.in_valid && bus.in_ready) acc_n++;
      if (!bus.in_ready) low_n++;
      if (bus.result_valid) rv_n++;
      @(negedge clk);
    end
    repeat (15) begin
      if (bus.result_valid) rv_n++;
      @(negedge clk);
    end
    chk("stream_accepts", acc_n, 3);
    chk("stream_ready_low", low_n, 30);
    chk("stream_results", rv_n, 3);

    // Reset during ACCUM discards the sample
    do_reset;
    bus.in_bits = 8'hFF; bus.exp_res = 1'b1; bus.train_en = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_in_ready", bus.in_ready, 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    rv_n = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.result_valid) rv_n++;
    end
    chk("abort_results", rv_n, 0);
    chk("abort_thresh", bus.thresh_out, 8);
    bus.wt_sel = 3'd0;
    #1 chk("abort_w0", bus.wt_out, 0);
    bus.wt_sel = 3'd7;
    #1 chk("abort_w7", bus.wt_out, 0);

    // 4-bit build, LR=6: weight and threshold clamp instead of wrapping
    do_reset;
    for (int s = 0; s < 9; s++) begin
      send_sat(sat_bits[s], sat_exp[s], r, er);
      chk($sformatf("sat%0d_result", s), r, int'(sat_res[s]));
      chk($sformatf("sat%0d_err", s), er, 1);
      chk($sformatf("sat%0d_thresh", s), sbus.thresh_out, sat_th[s]);
    end
    sbus.wt_sel = 3'd0;
    #1 chk("sat_w0", sbus.wt_out, 7);
    sbus.wt_sel = 3'd1;
    #1 chk("sat_w1", sbus.wt_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
